// File: rtl/sequence_generator.sv
// sequence_generator: writes len pseudo-random one-hot moves into sequence memory,
// one per address, under a selectable repetition rule, using a reseedable 16-bit LFSR.
module sequence_generator #(
  parameter int unsigned CELLS  = 16,
  parameter int unsigned ADDR_W = 5,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [1:0]        mode,
  input  logic              seed_load,
  input  logic [15:0]       seed_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CELLS-1:0]  mem_data,
  output logic              mem_wren
);
  localparam int unsigned IDX_W     = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned LEN_W     = ADDR_W + 1;
  localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  localparam logic [1:0] MODE_NO_REPEAT = 2'd1;
  localparam logic [1:0] MODE_DISTINCT  = 2'd2;
  localparam logic [1:0] MODE_RESERVED  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        mode_q, mode_d;
  logic [CELLS-1:0]  used_q, used_d;
  logic [IDX_W-1:0]  prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CELLS-1:0]  mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;

  logic [15:0]       lfsr_next_c;
  logic [IDX_W-1:0]  cand_c;
  logic              cand_ok_c;
  logic              req_bad_c;
  logic [LEN_W-1:0]  idx_next_c;

  // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  assign lfsr_next_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand_c      = lfsr_q[IDX_W-1:0];
  assign idx_next_c  = idx_q + LEN_W'(1);

  always_comb begin
    cand_ok_c = 1'b1;
    if (32'(cand_c) >= CELLS) cand_ok_c = 1'b0;
    if ((mode_q == MODE_NO_REPEAT) && prev_valid_q && (cand_c == prev_q)) cand_ok_c = 1'b0;
    if ((mode_q == MODE_DISTINCT) && used_q[cand_c]) cand_ok_c = 1'b0;
  end

  // Requests that can never complete are rejected straight to FINISH
  always_comb begin
    req_bad_c = 1'b0;
    if (mode == MODE_RESERVED) req_bad_c = 1'b1;
    if ((mode == MODE_DISTINCT) && (32'(len) > CELLS)) req_bad_c = 1'b1;
    if ((mode == MODE_NO_REPEAT) && (CELLS == 1) && (32'(len) > 1)) req_bad_c = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    len_d        = len_q;
    mode_d       = mode_q;
    used_d       = used_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    idx_d        = idx_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;

    case (state_q)
      ST_IDLE: begin
        if (seed_load) lfsr_d = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
        if (start) begin
          len_d        = len;
          mode_d       = mode;
          used_d       = '0;
          prev_valid_d = 1'b0;
          err_d        = 1'b0;
          idx_d        = '0;
          if (req_bad_c) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else if (len == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_DRAW;
          end
        end
      end
      ST_DRAW: begin
        lfsr_d = lfsr_next_c;
        if (cand_ok_c) begin
          mem_addr_d     = idx_q[ADDR_W-1:0];
          mem_data_d     = CELLS'(1) << cand_c;
          prev_d         = cand_c;
          prev_valid_d   = 1'b1;
          used_d[cand_c] = 1'b1;
          state_d        = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_next_c;
        state_d = (idx_next_c == len_q) ? ST_FINISH : ST_DRAW;
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the state being entered
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_FINISH);
    mem_wren_d = (state_d == ST_WRITE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= SEED_INIT;
      len_q        <= '0;
      mode_q       <= '0;
      used_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      used_q       <= used_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_wren_q   <= mem_wren_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_wren = mem_wren_q;
endmodule
